// File: rtl/mac_pkg.sv
// mac_pkg: shared constants and types for the MAC array result path.
//   MAC_LANES / MAC_DW / MAC_IDXW : lane count, accumulator width, lane index width
//   drain_state_t                 : result-drain FSM encoding
package mac_pkg;

  localparam int MAC_LANES = 8;
  localparam int MAC_DW    = 16;
  localparam int MAC_IDXW  = 3;

  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_SEND = 1'b1
  } drain_state_t;

endpackage

// File: rtl/mac_snap_reg.sv
// mac_snap_reg: LANES x DW parallel-load register bank with a lane-select read port.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears the bank)
//   load     : capture d into every lane on this edge
//   d        : all lanes, lane 0 in the low DW bits
//   sel      : lane index for the read port
//   q_sel    : contents of lane sel
//   q_all    : whole bank (used when one bank is copied into another)
module mac_snap_reg
  import mac_pkg::*;
#(
  parameter int LANES = MAC_LANES,
  parameter int DW    = MAC_DW,
  parameter int IDXW  = MAC_IDXW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [LANES-1:0][DW-1:0]   d,
  input  logic [IDXW-1:0]            sel,
  output logic [DW-1:0]              q_sel,
  output logic [LANES-1:0][DW-1:0]   q_all
);

  logic [LANES-1:0][DW-1:0] bank;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank <= '0;
    end else if (load) begin
      bank <= d;
    end
  end

  assign q_sel = bank[sel];
  assign q_all = bank;

endmodule

// File: rtl/mac_result_drain.sv
// mac_result_drain: snapshots the eight accumulator outputs of mac_array_8x8 on a
// capture pulse and streams them out one lane per beat over valid/ready.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   mac_out0..mac_out7    : accumulator outputs (unsigned, passed through unmodified)
//   capture               : single-cycle snapshot request
//   out_valid/out_ready   : beat handshake
//   out_data, out_lane    : lane value and its index
//   out_last              : high on the lane-7 beat
//   busy                  : snapshot draining
//   drop_cnt              : saturating count of ignored captures
// Build option: define MAC_DRAIN_PENDING_EN to add a one-deep pending snapshot
// buffer that absorbs a capture arriving mid-drain instead of dropping it.
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int LANES = MAC_LANES,
  parameter int DW    = MAC_DW,
  parameter int IDXW  = MAC_IDXW,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   mac_out0,
  input  logic [DW-1:0]   mac_out1,
  input  logic [DW-1:0]   mac_out2,
  input  logic [DW-1:0]   mac_out3,
  input  logic [DW-1:0]   mac_out4,
  input  logic [DW-1:0]   mac_out5,
  input  logic [DW-1:0]   mac_out6,
  input  logic [DW-1:0]   mac_out7,
  input  logic            capture,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [IDXW-1:0] out_lane,
  output logic            out_last,
  output logic            busy,
  output logic [CNTW-1:0] drop_cnt
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
  endfunction

  drain_state_t             state;
  logic [IDXW-1:0]          idx;
  logic [LANES-1:0][DW-1:0] mac_bank;
  logic [LANES-1:0][DW-1:0] act_d;
  logic [DW-1:0]            act_lane;
  logic [LANES-1:0][DW-1:0] act_all_unused;

  logic xfer, last_xfer;
  logic act_load, act_from_pend, pend_load, drop_inc;

  assign mac_bank = {mac_out7, mac_out6, mac_out5, mac_out4,
                     mac_out3, mac_out2, mac_out1, mac_out0};

  assign xfer      = (state == DRAIN_SEND) && out_ready;
  assign last_xfer = xfer && (idx == IDXW'(LANES - 1));

`ifdef MAC_DRAIN_PENDING_EN
  logic                     pend_valid;
  logic [LANES-1:0][DW-1:0] pend_all;
  logic [DW-1:0]            pend_lane_unused;

  mac_snap_reg #(.LANES(LANES), .DW(DW), .IDXW(IDXW)) u_pend (
    .clk   (clk),
    .rst   (rst),
    .load  (pend_load),
    .d     (mac_bank),
    .sel   ('0),
    .q_sel (pend_lane_unused),
    .q_all (pend_all)
  );

  assign act_d = act_from_pend ? pend_all : mac_bank;
`else
  assign act_d = mac_bank;
`endif

  mac_snap_reg #(.LANES(LANES), .DW(DW), .IDXW(IDXW)) u_act (
    .clk   (clk),
    .rst   (rst),
    .load  (act_load),
    .d     (act_d),
    .sel   (idx),
    .q_sel (act_lane),
    .q_all (act_all_unused)
  );

  // A new snapshot may enter the active bank when idle or on the final beat's
  // transfer, so back-to-back drains run without a bubble.
  always_comb begin
    act_load      = 1'b0;
    act_from_pend = 1'b0;
    pend_load     = 1'b0;
    drop_inc      = 1'b0;
    if (state == DRAIN_IDLE) begin
      act_load = capture;
    end else if (last_xfer) begin
`ifdef MAC_DRAIN_PENDING_EN
      if (pend_valid) begin
        act_load      = 1'b1;
        act_from_pend = 1'b1;
        pend_load     = capture;  // refills the slot being vacated this edge
      end else begin
        act_load = capture;
      end
`else
      act_load = capture;
`endif
    end else if (capture) begin
`ifdef MAC_DRAIN_PENDING_EN
      if (!pend_valid) pend_load = 1'b1;
      else             drop_inc  = 1'b1;
`else
      drop_inc = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DRAIN_IDLE;
      idx      <= '0;
      drop_cnt <= '0;
    end else begin
      if (act_load) begin
        state <= DRAIN_SEND;
        idx   <= '0;
      end else if (last_xfer) begin
        state <= DRAIN_IDLE;
        idx   <= '0;
      end else if (xfer) begin
        idx <= idx + IDXW'(1);
      end
      if (drop_inc) drop_cnt <= sat_inc(drop_cnt);
    end
  end

`ifdef MAC_DRAIN_PENDING_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
    end else if (pend_load) begin
      pend_valid <= 1'b1;
    end else if (act_from_pend) begin
      pend_valid <= 1'b0;
    end
  end
`endif

  // Outputs decode from state/idx/snapshot registers only; data is zeroed when idle.
  assign busy      = (state == DRAIN_SEND);
  assign out_valid = busy;
  assign out_lane  = idx;
  assign out_last  = busy && (idx == IDXW'(LANES - 1));
  assign out_data  = busy ? act_lane : '0;

endmodule

// File: tb/tb_mac_result_drain.sv
module tb_mac_result_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mo [8];
  logic        capture = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_last, busy;
  logic [15:0] out_data;
  logic [2:0]  out_lane;
  logic [7:0]  drop_cnt;

  mac_result_drain dut (
    .clk(clk), .rst(rst),
    .mac_out0(mo[0]), .mac_out1(mo[1]), .mac_out2(mo[2]), .mac_out3(mo[3]),
    .mac_out4(mo[4]), .mac_out5(mo[5]), .mac_out6(mo[6]), .mac_out7(mo[7]),
    .capture(capture), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          lane;
    bit          last;
  } beat_t;

  beat_t q[$];
  int tests = 0;
  int fails = 0;

`ifdef MAC_DRAIN_PENDING_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  // Transaction-level model: beats still owed for the active snapshot,
  // whether a second snapshot is waiting, and the drop tally.
  int left = 0;
  bit pend = 0;
  int drop_m = 0;
  int nxt_drop = 0, exp_drop = 0;
  bit nxt_busy = 0, exp_busy = 0;
  bit started = 0;

  always @(posedge clk) begin
    exp_drop <= nxt_drop;
    exp_busy <= nxt_busy;
  end

  function automatic void check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_snapshot();
    for (int i = 0; i < 8; i++) begin
      beat_t b;
      b.d = mo[i]; b.lane = i; b.last = (i == 7);
      q.push_back(b);
    end
  endfunction

  function automatic void model(bit r, bit cap, bit rdy);
    if (r) begin
      q.delete(); left = 0; pend = 0; drop_m = 0;
    end else begin
      bit x, lastx;
      x = (left > 0) && rdy;
      lastx = x && (left == 1);
      if (x) left--;
      if (lastx && pend) begin
        left = 8; pend = 0;     // its beats were queued when it was captured
      end
      if (cap) begin
        if (left == 0) begin
          push_snapshot(); left = 8;
        end else if (PEND_EN && !pend) begin
          push_snapshot(); pend = 1;
        end else if (drop_m < 255) begin
          drop_m++;
        end
      end
    end
    nxt_drop = drop_m;
    nxt_busy = (left > 0);
  endfunction

  // Called just after a rising edge: drive inputs for the coming cycle.
  task automatic step(bit r, bit cap, bit rdy);
    if (r) rdy = 0;
    rst = r; capture = cap; out_ready = rdy;
    model(r, cap, rdy);
    @(posedge clk); #1;
  endtask

  task automatic set_ramp(int base, int inc);
    for (int i = 0; i < 8; i++) mo[i] = 16'(base + inc * i);
  endtask

  // Monitor / scoreboard
  bit          prev_stall = 0;
  logic [15:0] prev_data;
  logic [2:0]  prev_lane;

  always @(negedge clk) begin
    if (started) begin
      check("busy", busy, exp_busy);
      check("out_valid", out_valid, exp_busy);
      check("drop_cnt", drop_cnt, exp_drop);
      if (prev_stall) begin
        check("stall_data", out_data, prev_data);
        check("stall_lane", out_lane, prev_lane);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          beat_t b;
          b = q.pop_front();
          check("beat_data", out_data, b.d);
          check("beat_lane", out_lane, b.lane);
          check("beat_last", out_last, b.last);
        end
      end
      prev_stall = out_valid && !out_ready && !rst;
      prev_data  = out_data;
      prev_lane  = out_lane;
    end
  end

  task automatic drain_all(string name);
    int n = 0;
    while ((q.size() != 0 || left != 0) && n < 200) begin
      step(0, 0, 1);
      n++;
    end
    step(0, 0, 1);
    check(name, q.size(), 0);
  endtask

  initial begin
    int bub;
    for (int i = 0; i < 8; i++) mo[i] = '0;
    @(posedge clk); #1;
    step(1, 0, 0);
    step(1, 0, 0);
    started = 1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 0);
    check("rst_lane", out_lane, 0);
    check("rst_last", out_last, 0);
    check("rst_drop", drop_cnt, 0);

    // Straight drain of 30..800
    mo = '{16'd30, 16'd80, 16'd150, 16'd240, 16'd350, 16'd480, 16'd630, 16'd800};
    step(0, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    check("drain1_empty", q.size(), 0);

    // Stalled drain, inputs overwritten right after capture
    mo = '{16'd30, 16'd80, 16'd150, 16'd240, 16'd350, 16'd480, 16'd630, 16'd800};
    step(0, 1, 1);
    for (int i = 0; i < 8; i++) mo[i] = 16'hFFFF;
    for (int i = 0; i < 40; i++) step(0, 0, (i % 4 == 0) || (i % 4 == 3));
    check("stall_drain_empty", q.size(), 0);

    // Three captures mid-drain
    step(1, 0, 0);
    set_ramp(100, 7);
    step(0, 1, 1);
    set_ramp(500, 3);
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 1);
    check("drop_mid_drain", drop_cnt, PEND_EN ? 2 : 3);
    check("mid_drain_empty", q.size(), 0);

    // Capture on the lane-7 transfer: no bubble
    step(1, 0, 0);
    set_ramp(900, 11);
    step(0, 1, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 1);
    set_ramp(1, 1);
    step(0, 1, 1);
    bub = 0;
    for (int i = 0; i < 8; i++) begin
      if (!out_valid) bub++;
      step(0, 0, 1);
    end
    check("no_bubble", bub, 0);
    drain_all("b2b_empty");

    // Saturating drop counter
    step(1, 0, 0);
    set_ramp(7, 5);
    step(0, 1, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 0);
    check("drop_sat", drop_cnt, 255);
    drain_all("sat_drain_empty");

    // Reset at beat 4, then restart
    set_ramp(40, 2);
    step(0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    step(1, 0, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_drop", drop_cnt, 0);
    set_ramp(77, 9);
    step(0, 1, 1);
    check("restart_lane", out_lane, 0);
    drain_all("restart_empty");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 8; i++) mo[i] = 16'($urandom);
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) != 0));
    end
    drain_all("final_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
